// File: rtl/mem_arbiter_if.sv
// Pipeline-side request/response bundle and the byte-wide RAM port of the
// memory arbiter. The slave modport is the arbiter; the master modport is the
// pipeline plus the RAM.
interface mem_arbiter_if #(parameter int ADDR_W = 17);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_inst;
  logic              if_busy;
  logic              ma_re;
  logic              ma_we;
  logic [2:0]        ma_width;
  logic [ADDR_W-1:0] ma_addr;
  logic [31:0]       ma_wdata;
  logic              ma_done;
  logic [31:0]       ma_rdata;
  logic              ma_busy;
  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_din;
  logic              ram_wr;
  logic [7:0]        ram_dout;

  modport slave (
    input  if_req, if_addr, ma_re, ma_we, ma_width, ma_addr, ma_wdata, ram_dout,
    output if_done, if_inst, if_busy, ma_done, ma_rdata, ma_busy, ram_a, ram_din, ram_wr
  );

  modport master (
    output if_req, if_addr, ma_re, ma_we, ma_width, ma_addr, ma_wdata, ram_dout,
    input  if_done, if_inst, if_busy, ma_done, ma_rdata, ma_busy, ram_a, ram_din, ram_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single byte-wide synchronous RAM between instruction fetch and
// the memory-access stage. Requests are split into byte cycles; reads are
// assembled little-endian (with load extension), writes are serialised.
module mem_arbiter #(
  parameter int ADDR_W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD_IF, RD_MA, WR_MA} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        n_q, n_d;
  logic              sext_q, sext_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_din_q, ram_din_d;
  logic              ram_wr_q, ram_wr_d;
  logic              if_done_q, if_done_d;
  logic              ma_done_q, ma_done_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [31:0]       ma_rdata_q, ma_rdata_d;

  logic [2:0]        nxt, lane;
  logic [ADDR_W-1:0] nxt_a;
  logic [31:0]       asm_w, ext_w;

  // State and datapath registers; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      n_q        <= '0;
      sext_q     <= 1'b0;
      base_q     <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      ram_a_q    <= '0;
      ram_din_q  <= '0;
      ram_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      ma_done_q  <= 1'b0;
      if_inst_q  <= '0;
      ma_rdata_q <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      sext_q     <= sext_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      ram_a_q    <= ram_a_d;
      ram_din_q  <= ram_din_d;
      ram_wr_q   <= ram_wr_d;
      if_done_q  <= if_done_d;
      ma_done_q  <= ma_done_d;
      if_inst_q  <= if_inst_d;
      ma_rdata_q <= ma_rdata_d;
    end
  end

  // Arbitration, byte sequencing and read assembly/extension.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    sext_d     = sext_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    ram_a_d    = ram_a_q;
    ram_din_d  = ram_din_q;
    ram_wr_d   = 1'b0;
    if_done_d  = 1'b0;
    ma_done_d  = 1'b0;
    if_inst_d  = if_inst_q;
    ma_rdata_d = ma_rdata_q;

    nxt   = cnt_q + 3'd1;
    nxt_a = base_q + ADDR_W'(nxt);
    // The byte on ram_dout now belongs to the address issued two edges ago.
    lane  = cnt_q - 3'd1;
    asm_w = rbuf_q;
    if (cnt_q != 3'd0) asm_w[{lane[1:0], 3'b000} +: 8] = bus.ram_dout;
    case (n_q)
      3'd1:    ext_w = {{24{sext_q & asm_w[7]}}, asm_w[7:0]};
      3'd2:    ext_w = {{16{sext_q & asm_w[15]}}, asm_w[15:0]};
      default: ext_w = asm_w;
    endcase

    case (state_q)
      IDLE: begin
        // A requester whose done pulse is still up is finishing, not asking again.
        if ((bus.ma_re | bus.ma_we) & ~ma_done_q) begin
          base_d  = bus.ma_addr;
          ram_a_d = bus.ma_addr;
          sext_d  = ~bus.ma_width[2];
          wdata_d = bus.ma_wdata;
          cnt_d   = '0;
          rbuf_d  = '0;
          case (bus.ma_width[1:0])
            2'b00:   n_d = 3'd1;
            2'b01:   n_d = 3'd2;
            default: n_d = 3'd4;
          endcase
          if (bus.ma_we) begin
            state_d   = WR_MA;
            ram_din_d = bus.ma_wdata[7:0];
            ram_wr_d  = 1'b1;
          end else begin
            state_d = RD_MA;
          end
        end else if (bus.if_req & ~if_done_q) begin
          base_d  = bus.if_addr;
          ram_a_d = bus.if_addr;
          sext_d  = 1'b0;
          n_d     = 3'd4;
          cnt_d   = '0;
          rbuf_d  = '0;
          state_d = RD_IF;
        end
      end
      RD_IF, RD_MA: begin
        cnt_d  = nxt;
        rbuf_d = asm_w;
        if (nxt < n_q) ram_a_d = nxt_a;
        if (cnt_q == n_q) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (state_q == RD_IF) begin
            if_done_d = 1'b1;
            if_inst_d = asm_w;
          end else begin
            ma_done_d  = 1'b1;
            ma_rdata_d = ext_w;
          end
        end
      end
      WR_MA: begin
        cnt_d = nxt;
        if (nxt < n_q) begin
          ram_a_d   = nxt_a;
          ram_din_d = wdata_q[{nxt[1:0], 3'b000} +: 8];
          ram_wr_d  = 1'b1;
        end else begin
          state_d   = IDLE;
          cnt_d     = '0;
          ma_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.if_done  = if_done_q;
  assign bus.if_inst  = if_inst_q;
  assign bus.ma_done  = ma_done_q;
  assign bus.ma_rdata = ma_rdata_q;
  assign bus.ram_a    = ram_a_q;
  assign bus.ram_din  = ram_din_q;
  assign bus.ram_wr   = ram_wr_q;
  assign bus.if_busy  = bus.if_req & ~if_done_q;
  assign bus.ma_busy  = (bus.ma_re | bus.ma_we) & ~ma_done_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a byte RAM model, a table of single
// transactions with hand-computed results, and hand-written multi-cycle cases.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst, rdy;
  mem_arbiter_if #(.ADDR_W(17)) bus ();

  mem_arbiter #(.ADDR_W(17)) dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0] mem [0:131071];

  // Synchronous byte RAM, clock-enabled by rdy.
  always @(posedge clk) begin
    if (rdy) begin
      if (bus.ram_wr) mem[bus.ram_a] <= bus.ram_din;
      bus.ram_dout <= mem[bus.ram_a];
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // op: 0 = fetch, 1 = load, 2 = store
  typedef struct {
    int          op;
    logic [2:0]  w;
    logic [16:0] a;
    logic [31:0] wd;
    logic [31:0] exp;
    int          lat;
    int          wr;
  } vec_t;

  task automatic run_op(input int op, input logic [2:0] w, input logic [16:0] a,
                        input logic [31:0] wd, output int cyc, output logic [31:0] data,
                        output int wrcnt);
    logic done;
    if (op == 0) begin
      bus.if_addr = a;
      bus.if_req  = 1'b1;
    end else begin
      bus.ma_addr  = a;
      bus.ma_width = w;
      bus.ma_wdata = wd;
      bus.ma_re    = (op == 1);
      bus.ma_we    = (op == 2);
    end
    cyc = 0;
    wrcnt = 0;
    done = 1'b0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
      if (bus.ram_wr) wrcnt++;
      done = (op == 0) ? bus.if_done : bus.ma_done;
    end
    data = (op == 0) ? bus.if_inst : bus.ma_rdata;
    bus.if_req = 1'b0;
    bus.ma_re  = 1'b0;
    bus.ma_we  = 1'b0;
    tick();
  endtask

  vec_t        vecs [15];
  int          cyc, wrcnt;
  logic [31:0] data;
  logic        busy_ok;

  initial begin
    vecs[0]  = '{0, 3'b000, 17'h00010, 32'h0,        32'h00100513, 6, 0};
    vecs[1]  = '{1, 3'b000, 17'h00100, 32'h0,        32'hFFFFFF80, 3, 0};
    vecs[2]  = '{1, 3'b100, 17'h00100, 32'h0,        32'h00000080, 3, 0};
    vecs[3]  = '{1, 3'b001, 17'h00200, 32'h0,        32'hFFFF8234, 4, 0};
    vecs[4]  = '{1, 3'b101, 17'h00200, 32'h0,        32'h00008234, 4, 0};
    vecs[5]  = '{1, 3'b010, 17'h00201, 32'h0,        32'h11F85682, 6, 0};
    vecs[6]  = '{1, 3'b000, 17'h00202, 32'h0,        32'h00000056, 3, 0};
    vecs[7]  = '{1, 3'b001, 17'h1FFFF, 32'h0,        32'h00007FAA, 4, 0};
    vecs[8]  = '{2, 3'b010, 17'h00300, 32'h12345678, 32'h0,        5, 4};
    vecs[9]  = '{1, 3'b010, 17'h00300, 32'h0,        32'h12345678, 6, 0};
    vecs[10] = '{1, 3'b100, 17'h00303, 32'h0,        32'h00000012, 3, 0};
    vecs[11] = '{2, 3'b000, 17'h00302, 32'hFFFFFFA5, 32'h0,        2, 1};
    vecs[12] = '{1, 3'b010, 17'h00300, 32'h0,        32'h12A55678, 6, 0};
    vecs[13] = '{1, 3'b011, 17'h00200, 32'h0,        32'hF8568234, 6, 0};
    vecs[14] = '{0, 3'b000, 17'h1FFFF, 32'h0,        32'h02017FAA, 6, 0};

    mem[17'h00010] <= 8'h13; mem[17'h00011] <= 8'h05;
    mem[17'h00012] <= 8'h10; mem[17'h00013] <= 8'h00;
    mem[17'h00100] <= 8'h80;
    mem[17'h00200] <= 8'h34; mem[17'h00201] <= 8'h82;
    mem[17'h00202] <= 8'h56; mem[17'h00203] <= 8'hF8; mem[17'h00204] <= 8'h11;
    mem[17'h1FFFF] <= 8'hAA; mem[17'h00000] <= 8'h7F;
    mem[17'h00001] <= 8'h01; mem[17'h00002] <= 8'h02;
    for (int i = 0; i < 4; i++) begin
      mem[17'h00300 + 17'(i)] <= 8'h00;
      mem[17'h00400 + 17'(i)] <= 8'h00;
    end

    rst = 1'b1; rdy = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ma_re = 1'b0; bus.ma_we = 1'b0; bus.ma_width = '0; bus.ma_addr = '0; bus.ma_wdata = '0;
    tick(); tick();
    chk("reset if_done",  32'(bus.if_done), 32'h0);
    chk("reset ma_done",  32'(bus.ma_done), 32'h0);
    chk("reset ram_wr",   32'(bus.ram_wr), 32'h0);
    chk("reset ram_a",    32'(bus.ram_a), 32'h0);
    chk("reset ram_din",  32'(bus.ram_din), 32'h0);
    chk("reset if_inst",  bus.if_inst, 32'h0);
    chk("reset ma_rdata", bus.ma_rdata, 32'h0);
    rst = 1'b0;
    tick();

    // Word fetch: address walk and done timing.
    bus.if_addr = 17'h00010;
    bus.if_req  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i < 4) chk($sformatf("fetch ram_a E%0d", i), 32'(bus.ram_a), 32'h10 + 32'(i));
      if (i < 5) chk($sformatf("fetch if_done early %0d", i), 32'(bus.if_done), 32'h0);
    end
    chk("fetch if_done", 32'(bus.if_done), 32'h1);
    chk("fetch if_inst", bus.if_inst, 32'h00100513);
    bus.if_req = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].wd, cyc, data, wrcnt);
      chk($sformatf("vec%0d latency", i), 32'(cyc), 32'(vecs[i].lat));
      chk($sformatf("vec%0d ram_wr cycles", i), 32'(wrcnt), 32'(vecs[i].wr));
      if (vecs[i].op != 2) chk($sformatf("vec%0d data", i), data, vecs[i].exp);
    end

    // Simultaneous fetch and byte load: MA first, then IF.
    for (int z = 0; z < 2; z++) begin
      bus.if_addr = 17'h00010; bus.if_req = 1'b1;
      bus.ma_addr = 17'h00100; bus.ma_width = (z == 0) ? 3'b000 : 3'b100; bus.ma_re = 1'b1;
      cyc = 0;
      while (!bus.ma_done && cyc < 40) begin tick(); cyc++; end
      chk($sformatf("both%0d ma_done cycle", z), 32'(cyc), 32'd3);
      chk($sformatf("both%0d ma_rdata", z), bus.ma_rdata, (z == 0) ? 32'hFFFFFF80 : 32'h00000080);
      chk($sformatf("both%0d if_done before", z), 32'(bus.if_done), 32'h0);
      bus.ma_re = 1'b0;
      while (!bus.if_done && cyc < 40) begin tick(); cyc++; end
      chk($sformatf("both%0d if_done cycle", z), 32'(cyc), 32'd9);
      chk($sformatf("both%0d if_inst", z), bus.if_inst, 32'h00100513);
      bus.if_req = 1'b0;
      tick();
    end

    // Store with address wrap.
    run_op(2, 3'b001, 17'h1FFFF, 32'hDEADBEEF, cyc, data, wrcnt);
    chk("wrap store latency", 32'(cyc), 32'd3);
    chk("wrap store ram_wr cycles", 32'(wrcnt), 32'd2);
    chk("wrap store byte 1FFFF", 32'(mem[17'h1FFFF]), 32'hEF);
    chk("wrap store byte 00000", 32'(mem[17'h00000]), 32'hBE);

    // Load arriving mid-fetch waits; no preemption.
    bus.if_addr = 17'h00010; bus.if_req = 1'b1;
    tick(); tick();
    cyc = 2;
    bus.ma_addr = 17'h00200; bus.ma_width = 3'b010; bus.ma_re = 1'b1;
    busy_ok = 1'b1;
    while (!bus.if_done && cyc < 40) begin
      tick(); cyc++;
      if (!bus.ma_busy) busy_ok = 1'b0;
    end
    chk("nopreempt if_done cycle", 32'(cyc), 32'd6);
    chk("nopreempt if_inst", bus.if_inst, 32'h00100513);
    bus.if_req = 1'b0;
    while (!bus.ma_done && cyc < 40) begin
      tick(); cyc++;
      if (!bus.ma_done && !bus.ma_busy) busy_ok = 1'b0;
    end
    chk("nopreempt ma_done cycle", 32'(cyc), 32'd12);
    chk("nopreempt ma_rdata", bus.ma_rdata, 32'hF8568234);
    chk("nopreempt ma_busy held", 32'(busy_ok), 32'h1);
    bus.ma_re = 1'b0;
    tick();

    // rdy low for 3 cycles mid-fetch.
    bus.if_addr = 17'h00010; bus.if_req = 1'b1;
    tick(); tick(); tick();
    cyc = 3;
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); cyc++;
      chk($sformatf("stall ram_a %0d", i), 32'(bus.ram_a), 32'h12);
      chk($sformatf("stall if_done %0d", i), 32'(bus.if_done), 32'h0);
    end
    rdy = 1'b1;
    while (!bus.if_done && cyc < 40) begin tick(); cyc++; end
    chk("stall if_done cycle", 32'(cyc), 32'd9);
    chk("stall if_inst", bus.if_inst, 32'h00100513);
    bus.if_req = 1'b0;
    tick();

    // Reset during the second byte of a word store.
    bus.ma_addr = 17'h00400; bus.ma_width = 3'b010; bus.ma_wdata = 32'hCAFEF00D; bus.ma_we = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rst store ram_wr", 32'(bus.ram_wr), 32'h0);
    chk("rst store ram_a", 32'(bus.ram_a), 32'h0);
    chk("rst store ma_done", 32'(bus.ma_done), 32'h0);
    bus.ma_we = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst store no done %0d", i), 32'(bus.ma_done), 32'h0);
    end
    chk("rst store byte 400", 32'(mem[17'h00400]), 32'h0D);
    chk("rst store byte 401", 32'(mem[17'h00401]), 32'hF0);
    chk("rst store byte 402", 32'(mem[17'h00402]), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
